vxe_vpu_cmd_bcast: RTL and testbench

//  Command broadcaster sitting directly upstream of the vector units.

---
 rtl/vxe_vpu_cmd_bcast.sv | 116 +++++++++++
 tb/tb_vxe_vpu_cmd_bcast.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vxe_vpu_cmd_bcast.sv
// Command broadcaster: buffers destination-tagged commands in a small FIFO and
// delivers each one to every selected vector unit, collecting per-unit acks.
module vxe_vpu_cmd_bcast #(
  parameter int NR_VPUS    = 2,
  parameter int DEPTH_POW2 = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_cmd_wr,
  output logic               o_cmd_rdy,
  input  logic [NR_VPUS-1:0] i_cmd_dst,
  input  logic [4:0]         i_cmd_op,
  input  logic [2:0]         i_cmd_th,
  input  logic [47:0]        i_cmd_pl,
  output logic [NR_VPUS-1:0] o_vpu_cmd_sel,
  input  logic [NR_VPUS-1:0] i_vpu_cmd_ack,
  output logic [4:0]         o_vpu_cmd_op,
  output logic [2:0]         o_vpu_cmd_th,
  output logic [47:0]        o_vpu_cmd_pl,
  input  logic [NR_VPUS-1:0] i_vpu_busy,
  input  logic [NR_VPUS-1:0] i_vpu_err,
  output logic               o_busy,
  output logic               o_err
);

  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam int ENT_W = NR_VPUS + 5 + 3 + 48;
  localparam logic [DEPTH_POW2:0]   CNT_FULL = (DEPTH_POW2 + 1)'(DEPTH);
  localparam logic [DEPTH_POW2:0]   CNT_ONE  = (DEPTH_POW2 + 1)'(1);
  localparam logic [DEPTH_POW2-1:0] PTR_ONE  = DEPTH_POW2'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_POW2-1:0] wptr, rptr;
  logic [DEPTH_POW2:0]   count;
  logic                  push, pop, load, empty, full;
  logic [NR_VPUS-1:0]    pending, pending_nxt;

  logic [NR_VPUS-1:0] head_dst;
  logic [4:0]         head_op;
  logic [2:0]         head_th;
  logic [47:0]        head_pl;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign push  = i_cmd_wr && !full;
  assign {head_dst, head_op, head_th, head_pl} = mem[rptr];

  // Storage is data only; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {i_cmd_dst, i_cmd_op, i_cmd_th, i_cmd_pl};
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    pop         = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A command with no destination is consumed without ever selecting a unit.
          if (head_dst != '0) begin
            load        = 1'b1;
            pending_nxt = head_dst;
            state_nxt   = SEND;
          end
        end
      end
      SEND: begin
        pending_nxt = pending & ~i_vpu_cmd_ack;
        if (pending_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      pending      <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      o_vpu_cmd_op <= '0;
      o_vpu_cmd_th <= '0;
      o_vpu_cmd_pl <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (load) begin
        o_vpu_cmd_op <= head_op;
        o_vpu_cmd_th <= head_th;
        o_vpu_cmd_pl <= head_pl;
      end
    end
  end

  // pending is zero whenever the FSM is idle, so it doubles as the select.
  assign o_vpu_cmd_sel = pending;
  assign o_cmd_rdy     = !full;
  assign o_busy        = !empty || (state == SEND) || (|i_vpu_busy);
  assign o_err         = |i_vpu_err;

endmodule

// File: tb/tb_vxe_vpu_cmd_bcast.sv
// Directed bench for vxe_vpu_cmd_bcast: per-cycle vector table plus
// hand-written sequences for FIFO fill/drain, back-to-back issue and reset.
module tb_vxe_vpu_cmd_bcast;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_wr;
  logic        cmd_rdy;
  logic [1:0]  cmd_dst;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_th;
  logic [47:0] cmd_pl;
  logic [1:0]  vpu_sel;
  logic [1:0]  vpu_ack;
  logic [4:0]  vpu_op;
  logic [2:0]  vpu_th;
  logic [47:0] vpu_pl;
  logic [1:0]  vpu_busy;
  logic [1:0]  vpu_err;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vxe_vpu_cmd_bcast #(.NR_VPUS(2), .DEPTH_POW2(2)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_cmd_wr      (cmd_wr),
    .o_cmd_rdy     (cmd_rdy),
    .i_cmd_dst     (cmd_dst),
    .i_cmd_op      (cmd_op),
    .i_cmd_th      (cmd_th),
    .i_cmd_pl      (cmd_pl),
    .o_vpu_cmd_sel (vpu_sel),
    .i_vpu_cmd_ack (vpu_ack),
    .o_vpu_cmd_op  (vpu_op),
    .o_vpu_cmd_th  (vpu_th),
    .o_vpu_cmd_pl  (vpu_pl),
    .i_vpu_busy    (vpu_busy),
    .i_vpu_err     (vpu_err),
    .o_busy        (busy),
    .o_err         (err)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  dst;
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
    logic [1:0]  ack;
    logic [1:0]  vb;
    logic [1:0]  ve;
    logic [1:0]  e_sel;
    logic        e_rdy;
    logic        e_busy;
    logic        e_err;
    logic [4:0]  e_op;
    logic [2:0]  e_th;
    logic [47:0] e_pl;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Expected outputs are those seen during the cycle the inputs are applied.
    //           wr dst   op     th    pl        ack    vb     ve     sel   rdy   bsy   err   op     th    pl
    vecs[0]  = '{1, 2'b11, 5'h03, 3'd3, 48'h1234, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 48'h0};
    vecs[1]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'h00, 3'd0, 48'h0};
    vecs[2]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[3]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[4]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[5]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b01, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[6]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[7]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[8]  = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[9]  = '{1, 2'b00, 5'h05, 3'd1, 48'h5,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[10] = '{1, 2'b01, 5'h06, 3'd2, 48'h6,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[11] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'h03, 3'd3, 48'h1234};
    vecs[12] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 5'h06, 3'd2, 48'h6};
    vecs[13] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'h06, 3'd2, 48'h6};
    vecs[14] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 5'h06, 3'd2, 48'h6};
    vecs[15] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'h06, 3'd2, 48'h6};
    vecs[16] = '{0, 2'b00, 5'h00, 3'd0, 48'h0,    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'h06, 3'd2, 48'h6};

    nrst = 1'b0; cmd_wr = 1'b0; cmd_dst = '0; cmd_op = '0; cmd_th = '0; cmd_pl = '0;
    vpu_ack = '0; vpu_busy = '0; vpu_err = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("reset_sel",  64'(vpu_sel), 64'(2'b00));
    chk("reset_rdy",  64'(cmd_rdy), 64'(1'b1));
    chk("reset_busy", 64'(busy),    64'(1'b0));
    chk("reset_op",   64'(vpu_op),  64'(5'h00));
    chk("reset_pl",   64'(vpu_pl),  64'(48'h0));

    for (int i = 0; i < 17; i++) begin
      cmd_wr = vecs[i].wr; cmd_dst = vecs[i].dst; cmd_op = vecs[i].op;
      cmd_th = vecs[i].th; cmd_pl = vecs[i].pl;
      vpu_ack = vecs[i].ack; vpu_busy = vecs[i].vb; vpu_err = vecs[i].ve;
      #1;
      chk($sformatf("vec%0d_sel", i),  64'(vpu_sel), 64'(vecs[i].e_sel));
      chk($sformatf("vec%0d_rdy", i),  64'(cmd_rdy), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 64'(busy),    64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i),  64'(err),     64'(vecs[i].e_err));
      chk($sformatf("vec%0d_op", i),   64'(vpu_op),  64'(vecs[i].e_op));
      chk($sformatf("vec%0d_th", i),   64'(vpu_th),  64'(vecs[i].e_th));
      chk($sformatf("vec%0d_pl", i),   64'(vpu_pl),  64'(vecs[i].e_pl));
      @(negedge clk);
    end
    cmd_wr = 1'b0; vpu_ack = '0; vpu_busy = '0; vpu_err = '0;

    // Fill: hold write with acks withheld until the FIFO reports full.
    begin
      int n = 0;
      int got = 0;
      bit stop = 0;
      cmd_wr = 1'b1; cmd_dst = 2'b11; cmd_th = 3'd0; cmd_pl = 48'h0;
      for (int c = 0; c < 20 && !stop; c++) begin
        cmd_op = 5'(n + 1);
        #1;
        if (!cmd_rdy) stop = 1;
        else begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
      cmd_wr = 1'b0;
      chk("fill_accepted", 64'(n),       64'(5));
      chk("fill_rdy",      64'(cmd_rdy), 64'(1'b0));
      chk("fill_busy",     64'(busy),    64'(1'b1));
      chk("fill_sel",      64'(vpu_sel), 64'(2'b11));
      chk("fill_head_op",  64'(vpu_op),  64'(5'h01));
      vpu_ack = 2'b11;
      for (int c = 0; c < 20 && got < 5; c++) begin
        if (vpu_sel == 2'b11) begin
          chk($sformatf("drain%0d_op", got), 64'(vpu_op), 64'(got + 1));
          got++;
        end
        @(negedge clk);
        #1;
      end
      chk("drain_count", 64'(got), 64'(5));
      @(negedge clk);
      vpu_ack = 2'b00;
      #1;
      chk("drain_idle_busy", 64'(busy),    64'(1'b0));
      chk("drain_idle_sel",  64'(vpu_sel), 64'(2'b00));
    end

    // Back-to-back commands with simultaneous acks: 2-cycle period.
    @(negedge clk);
    cmd_wr = 1'b1; cmd_dst = 2'b11; cmd_op = 5'h0A; cmd_th = 3'd5; cmd_pl = 48'hAAAA;
    @(negedge clk);
    cmd_op = 5'h0B; cmd_pl = 48'hBBBB;
    @(negedge clk);
    cmd_wr = 1'b0; vpu_ack = 2'b11;
    #1;
    chk("b2b_a_sel", 64'(vpu_sel), 64'(2'b11));
    chk("b2b_a_op",  64'(vpu_op),  64'(5'h0A));
    @(negedge clk); #1;
    chk("b2b_gap_sel", 64'(vpu_sel), 64'(2'b00));
    @(negedge clk); #1;
    chk("b2b_b_sel", 64'(vpu_sel), 64'(2'b11));
    chk("b2b_b_pl",  64'(vpu_pl),  64'(48'hBBBB));
    @(negedge clk); #1;
    chk("b2b_end_sel", 64'(vpu_sel), 64'(2'b00));
    vpu_ack = 2'b00;

    // Reset while a command is in flight.
    @(negedge clk);
    cmd_wr = 1'b1; cmd_dst = 2'b01; cmd_op = 5'h11; cmd_pl = 48'h77;
    @(negedge clk);
    cmd_wr = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_sel", 64'(vpu_sel), 64'(2'b01));
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1; vpu_ack = 2'b01;
    #1;
    chk("rst_sel",  64'(vpu_sel), 64'(2'b00));
    chk("rst_rdy",  64'(cmd_rdy), 64'(1'b1));
    chk("rst_busy", 64'(busy),    64'(1'b0));
    chk("rst_op",   64'(vpu_op),  64'(5'h00));
    @(negedge clk);
    vpu_ack = 2'b00;
    #1;
    chk("late_ack_sel",  64'(vpu_sel), 64'(2'b00));
    chk("late_ack_busy", 64'(busy),    64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
